uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Parametrised UART transmit engine: accepts parallel words through a one-entry holding register with a valid/ready handshake and serialises them as start / data (LSB first) / optional parity / one-or-two stop bits. Bit timing comes from an external one-cycle `baud_tick` strobe. Back-to-back frames are sent without an idle bit period between them. It replaces the fixed-format TX controller in the UART peripheral and sits between the bus-side TX register and the pad.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame; legal range 5..9.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `baud_tick`  in  1  one-cycle strobe, one per bit period; may be held high (one bit per clock).
- `P_DATA`  in  WIDTH  word to transmit.
- `Data_Valid`  in  1  producer offers `P_DATA`.
- `data_ready`  out  1  holding register empty; transfer occurs when `Data_Valid & data_ready`.
- `PAR_EN`  in  1  1 = append parity bit.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `STOP2`  in  1  1 = two stop bits.
- `TX_OUT`  out  1  serial line, registered, idle high.
- `busy`  out  1  frame in progress (state != IDLE).
- `frame_done`  out  1  one-cycle pulse on the edge that ends the last stop bit.

## Operation
- Holding register: on a transfer, capture `P_DATA`, `PAR_EN`, `PAR_TYP`, `STOP2`; `data_ready` drops on the next cycle. While `data_ready`=0, `Data_Valid` is ignored and `P_DATA` is not sampled.
- Load: the holding contents move to the frame registers (shift register, bit counter cleared, parity latched, config latched). `data_ready` rises on the next cycle. Parity = XOR of data bits (even); inverted for odd.
- States: IDLE, START, DATA, PARITY, STOP1, STOP_2. All transitions except reset happen only on edges where `baud_tick`=1.
  - IDLE: if holding full, go to START and load.
  - START -> DATA.
  - DATA: shift right each tick. At counter = WIDTH-1, go to PARITY if latched `PAR_EN`, else STOP1.
  - PARITY -> STOP1.
  - STOP1: go to STOP_2 if latched `STOP2`; otherwise end the frame.
  - STOP_2: end the frame.
  - End of frame: pulse `frame_done`. If holding full, go to START and load (no idle period); else go to IDLE.
- `TX_OUT` per state, registered on the same edge as the state change:
  - IDLE = 1, START = 0.
  - DATA = current shift LSB.
  - PARITY = latched parity.
  - STOP1 / STOP_2 = 1.
- Config inputs changing mid-frame have no effect until the next load.
- Reset (any state, including mid-frame):
  - State IDLE; holding register emptied (pending word discarded).
  - Outputs: `TX_OUT`=1, `busy`=0, `data_ready`=1, `frame_done`=0 on the cycle after `RST` is sampled high.

## Timing
- Transfer to `data_ready` low: 1 cycle.
- Transfer to start bit on line: first `baud_tick` at or after the cycle following the transfer, plus 1 cycle of register delay.
- Each bit lasts exactly one tick interval. Frame length: 1 + WIDTH + PAR_EN + 1 + STOP2 ticks.
- Back-to-back: the next start bit begins on the same edge where the previous stop bit ends.
- `data_ready` re-asserts 1 cycle after each load. A new word can therefore be queued for almost a full frame.
- `baud_tick` continuously high: every state lasts 1 clock; behaviour is otherwise unchanged.

## Structure
- Package `uart_tx_pkg` holds:
  - state enum `uart_tx_state_e`;
  - parity-type constants `PAR_EVEN`=0, `PAR_ODD`=1;
  - stop-bit constants.
- Sub-module `uart_tx_serializer` holds the WIDTH shift register, bit counter, parity calculation and `ser_done` (counter = WIDTH-1). The engine holds the FSM, holding register, handshake and output register.

## Test plan
- Reset: assert `RST` 2 cycles mid-DATA -> next cycle `TX_OUT`=1, `busy`=0, `data_ready`=1; a pending word is never transmitted.
- WIDTH=8, 0xA5, no parity, 1 stop, tick every 4 clocks -> line 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; one `frame_done`; `busy` high for 40 clocks.
- Parity: 0x07 even -> parity bit 1; 0x07 odd -> 0; 0x00 odd -> 1; frame is 11 ticks.
- `STOP2`=1, 0xFF -> stop level held 2 tick periods; changing `STOP2` mid-frame does not alter the current frame.
- Back-to-back: 0x12 then 0x34 offered while the first is sending -> second start bit immediately follows the first stop bit; two `frame_done` pulses 10 ticks apart.
- Handshake: `Data_Valid` held with 3 words while `data_ready`=0 -> each accepted only on ready cycles, none lost or duplicated. WIDTH=5 and WIDTH=9 builds repeat the 0xA5-style check with the correct bit counts.

Source files
------------

// File: rtl/uart_tx_engine_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit engine: FSM state encoding,
// parity-type and stop-bit selector constants, and the legal WIDTH range.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

   // Frame sequencer states; IDLE must stay at zero so busy = (state != IDLE).
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } uart_tx_state_e;

   // PAR_TYP encoding
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // STOP2 encoding
   localparam logic STOP_ONE = 1'b0;
   localparam logic STOP_TWO = 1'b1;

   // Supported data bits per frame
   localparam int WIDTH_MIN = 5;
   localparam int WIDTH_MAX = 9;

endpackage

// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
// Producer-side handshake and per-word frame configuration of the UART
// transmit engine.
//   P_DATA     word to transmit (WIDTH bits)
//   Data_Valid producer offers P_DATA
//   data_ready engine holding register is empty
//   PAR_EN     append parity bit
//   PAR_TYP    0 = even, 1 = odd
//   STOP2      1 = two stop bits
// master = producer (bus-side TX register), slave = engine.
// -----------------------------------------------------------------------------
interface uart_tx_engine_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] P_DATA;
   logic             Data_Valid;
   logic             data_ready;
   logic             PAR_EN;
   logic             PAR_TYP;
   logic             STOP2;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
      input  data_ready
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
      output data_ready
   );
endinterface

// File: rtl/uart_tx_engine_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Frame datapath: WIDTH-bit right-shifting register, data bit counter and
// parity latch for the frame currently on the line.
//   clk_i      system clock
//   rst_i      synchronous active-high reset (counter only)
//   load_i     capture data_i / par_typ_i, clear the counter
//   data_i     word being loaded
//   par_typ_i  parity type of the word being loaded
//   shift_i    advance the shift register by one bit
//   cnt_en_i   advance the data bit counter
//   bit_o      current LSB of the shift register (next data bit to send)
//   par_o      parity bit of the loaded word
//   done_o     counter has reached WIDTH-1 (last data bit on the line)
// -----------------------------------------------------------------------------
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             par_typ_i,
   input  logic             shift_i,
   input  logic             cnt_en_i,
   output logic             bit_o,
   output logic             par_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;

   function automatic logic calc_parity(input logic [WIDTH-1:0] data,
                                        input logic             typ);
      return (^data) ^ (typ == PAR_ODD);
   endfunction

   always_comb begin
      shift_d = shift_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = data_i;
         par_d   = calc_parity(data_i, par_typ_i);
         cnt_d   = '0;
      end else begin
         if (shift_i) begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
         end
         if (cnt_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Shift data and parity carry no reset: they are always loaded before use.
   always_ff @(posedge clk_i) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_o  = shift_q[0];
   assign par_o  = par_q;
   assign done_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmit engine. A one-entry holding register with valid/ready
// handshake feeds a frame sequencer that emits start / WIDTH data bits
// (LSB first) / optional parity / one or two stop bits, one bit per
// baud_tick. A word waiting in the holding register is started on the same
// edge that ends the previous stop bit, so back-to-back frames have no gap.
//   CLK         system clock
//   RST         synchronous active-high reset
//   baud_tick   one-cycle strobe per bit period (may be held high)
//   tx_if       producer handshake + per-word config (slave modport)
//   TX_OUT      registered serial line, idle high
//   busy        frame in progress
//   frame_done  one-cycle pulse after the edge that ends the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_engine
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             baud_tick,
   uart_tx_engine_if.slave  tx_if,
   output logic             TX_OUT,
   output logic             busy,
   output logic             frame_done
);

   uart_tx_state_e   state_q, state_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_data_q;
   logic             hold_par_en_q, hold_par_typ_q, hold_stop2_q;
   logic             par_en_q, stop2_q;
   logic             tx_q, tx_d;
   logic             fd_q, fd_d;

   logic             xfer;
   logic             load;
   logic             shift;
   logic             cnt_en;
   logic             frame_end;
   logic             ser_bit, ser_par, ser_done;

   // Holding register is only written while empty, so P_DATA is never
   // sampled while data_ready is low.
   assign xfer = tx_if.Data_Valid & ~hold_full_q;

   uart_tx_serializer #(
      .WIDTH (WIDTH)
   ) u_ser (
      .clk_i     (CLK),
      .rst_i     (RST),
      .load_i    (load),
      .data_i    (hold_data_q),
      .par_typ_i (hold_par_typ_q),
      .shift_i   (shift),
      .cnt_en_i  (cnt_en),
      .bit_o     (ser_bit),
      .par_o     (ser_par),
      .done_o    (ser_done)
   );

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      fd_d      = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      cnt_en    = 1'b0;
      frame_end = 1'b0;

      if (baud_tick) begin
         case (state_q)
            ST_IDLE: begin
               tx_d = 1'b1;
               if (hold_full_q) begin
                  load    = 1'b1;
                  state_d = ST_START;
                  tx_d    = 1'b0;
               end
            end
            // Leaving START puts data bit 0 on the line; the counter only
            // advances on DATA ticks, so it reads WIDTH-1 while the last bit
            // is being sent.
            ST_START: begin
               state_d = ST_DATA;
               tx_d    = ser_bit;
               shift   = 1'b1;
            end
            ST_DATA: begin
               if (ser_done) begin
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = ser_par;
                  end else begin
                     state_d = ST_STOP1;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d   = ser_bit;
                  shift  = 1'b1;
                  cnt_en = 1'b1;
               end
            end
            ST_PARITY: begin
               state_d = ST_STOP1;
               tx_d    = 1'b1;
            end
            ST_STOP1: begin
               if (stop2_q == STOP_TWO) begin
                  state_d = ST_STOP2;
                  tx_d    = 1'b1;
               end else begin
                  frame_end = 1'b1;
               end
            end
            ST_STOP2: begin
               frame_end = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         endcase

         // A pending word starts on the very edge that closes the frame.
         if (frame_end) begin
            fd_d = 1'b1;
            if (hold_full_q) begin
               load    = 1'b1;
               state_d = ST_START;
               tx_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         end
      end
   end

   // Transfer and load are mutually exclusive: one needs empty, one full.
   always_comb begin
      hold_full_d = hold_full_q;
      if (xfer) begin
         hold_full_d = 1'b1;
      end else if (load) begin
         hold_full_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         fd_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         fd_q        <= fd_d;
      end
   end

   // Word and frame configuration; validity is tracked by hold_full_q/state_q.
   always_ff @(posedge CLK) begin
      if (xfer) begin
         hold_data_q    <= tx_if.P_DATA;
         hold_par_en_q  <= tx_if.PAR_EN;
         hold_par_typ_q <= tx_if.PAR_TYP;
         hold_stop2_q   <= tx_if.STOP2;
      end
      if (load) begin
         par_en_q <= hold_par_en_q;
         stop2_q  <= hold_stop2_q;
      end
   end

   assign tx_if.data_ready = ~hold_full_q;
   assign TX_OUT           = tx_q;
   assign busy             = (state_q != ST_IDLE);
   assign frame_done       = fd_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;
   import uart_tx_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   logic baud_tick;

   always #5 CLK = ~CLK;

   uart_tx_engine_if #(.WIDTH(8)) if8 ();
   uart_tx_engine_if #(.WIDTH(5)) if5 ();
   uart_tx_engine_if #(.WIDTH(9)) if9 ();

   logic tx8, tx5, tx9, busy8, busy5, busy9, fd8, fd5, fd9;
   logic [2:0] tx_w, busy_w, fd_w, rdy_w;

   assign tx_w   = {tx9, tx5, tx8};
   assign busy_w = {busy9, busy5, busy8};
   assign fd_w   = {fd9, fd5, fd8};
   assign rdy_w  = {if9.data_ready, if5.data_ready, if8.data_ready};

   uart_tx_engine #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .tx_if(if8),
      .TX_OUT(tx8), .busy(busy8), .frame_done(fd8));
   uart_tx_engine #(.WIDTH(5)) dut5 (
      .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .tx_if(if5),
      .TX_OUT(tx5), .busy(busy5), .frame_done(fd5));
   uart_tx_engine #(.WIDTH(9)) dut9 (
      .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .tx_if(if9),
      .TX_OUT(tx9), .busy(busy9), .frame_done(fd9));

   int n_total = 0;
   int n_pass  = 0;

   // Baud strobe: one clock high every tick_div clocks, or always high.
   int tick_div = 4;
   int tcnt = 0;
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge CLK);
         if (tick_div <= 1) begin
            baud_tick = 1'b1;
         end else begin
            baud_tick = (tcnt == 0);
            tcnt = (tcnt + 1) % tick_div;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs(input int idx, input logic [8:0] d, input logic v,
                             input logic pen, input logic ptyp, input logic st2);
      case (idx)
         0: begin if8.P_DATA = d[7:0]; if8.Data_Valid = v; if8.PAR_EN = pen; if8.PAR_TYP = ptyp; if8.STOP2 = st2; end
         1: begin if5.P_DATA = d[4:0]; if5.Data_Valid = v; if5.PAR_EN = pen; if5.PAR_TYP = ptyp; if5.STOP2 = st2; end
         default: begin if9.P_DATA = d; if9.Data_Valid = v; if9.PAR_EN = pen; if9.PAR_TYP = ptyp; if9.STOP2 = st2; end
      endcase
   endtask

   task automatic set_valid(input int idx, input logic v);
      case (idx)
         0: if8.Data_Valid = v;
         1: if5.Data_Valid = v;
         default: if9.Data_Valid = v;
      endcase
   endtask

   // Called at a negedge; returns at the negedge after the transfer.
   task automatic send_word(input int idx, input logic [8:0] d, input logic pen,
                            input logic ptyp, input logic st2, input string tag);
      int t = 0;
      while (rdy_w[idx] !== 1'b1 && t < 400) begin
         @(negedge CLK);
         t++;
      end
      chk({tag, "_ready_wait"}, 32'(t < 400), 1);
      set_inputs(idx, d, 1'b1, pen, ptyp, st2);
      @(negedge CLK);
      set_valid(idx, 1'b0);
      chk({tag, "_ready_drop"}, 32'(rdy_w[idx]), 0);
   endtask

   // mode 0: wait for a start bit from idle; mode 1: start bit must begin at
   // the next sample (back-to-back), together with the previous frame_done.
   task automatic check_frame(input int idx, input logic [8:0] d, input int w,
                              input logic pen, input logic pbit, input logic st2,
                              input int mode, input int div, input string tag);
      logic exp_bits[16];
      int n;
      int t;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < w; i++) exp_bits[1 + i] = d[i];
      n = 1 + w;
      if (pen) begin exp_bits[n] = pbit; n++; end
      exp_bits[n] = 1'b1; n++;
      if (st2) begin exp_bits[n] = 1'b1; n++; end
      if (mode == 0) begin
         t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (tx_w[idx] !== 1'b0 && t < 500);
         chk({tag, "_start_seen"}, 32'(tx_w[idx]), 0);
         if (t >= 500) return;
      end else begin
         @(negedge CLK);
      end
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < div; c++) begin
            if (!(b == 0 && c == 0)) @(negedge CLK);
            chk($sformatf("%s_bit%0d_clk%0d", tag, b, c),
                32'({tx_w[idx], busy_w[idx], fd_w[idx]}),
                32'({exp_bits[b], 1'b1, (b == 0 && c == 0 && mode == 1)}));
         end
      end
   endtask

   task automatic check_idle(input int idx, input string tag);
      @(negedge CLK);
      chk({tag, "_end"}, 32'({tx_w[idx], busy_w[idx], fd_w[idx]}), 32'(3'b101));
      @(negedge CLK);
      chk({tag, "_idle"}, 32'({tx_w[idx], busy_w[idx], fd_w[idx]}), 32'(3'b100));
   endtask

   task automatic check_quiet(input int idx, input int ncyc, input string tag);
      logic seen = 1'b0;
      repeat (ncyc) begin
         @(negedge CLK);
         if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 0);
   endtask

   task automatic hold_feed(input int idx, input logic [8:0] w0, input logic [8:0] w1,
                            input logic [8:0] w2);
      logic [8:0] words[3];
      int t;
      words[0] = w0; words[1] = w1; words[2] = w2;
      set_inputs(idx, words[0], 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         t = 0;
         while (rdy_w[idx] !== 1'b1 && t < 400) begin
            @(negedge CLK);
            t++;
         end
         chk($sformatf("hs_ready_wait%0d", k), 32'(t < 400), 1);
         @(negedge CLK);
         chk($sformatf("hs_taken%0d", k), 32'(rdy_w[idx]), 0);
         if (k < 2) set_inputs(idx, words[k + 1], 1'b1, 1'b0, 1'b0, 1'b0);
         else set_valid(idx, 1'b0);
      end
   endtask

   initial begin
      int t;
      RST = 1'b1;
      for (int i = 0; i < 3; i++) set_inputs(i, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_state_dut%0d", i),
             32'({tx_w[i], busy_w[i], rdy_w[i], fd_w[i]}), 32'(4'b1010));
      RST = 1'b0;
      @(negedge CLK);

      // 0xA5, no parity, one stop bit: line 0,1,0,1,0,0,1,0,1,1
      send_word(0, 9'h0A5, 1'b0, PAR_EVEN, STOP_ONE, "a5");
      check_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 0, 4, "a5");
      check_idle(0, "a5");

      // Parity: 0x07 even -> 1, 0x07 odd -> 0, 0x00 odd -> 1
      send_word(0, 9'h007, 1'b1, PAR_EVEN, STOP_ONE, "p07e");
      check_frame(0, 9'h007, 8, 1'b1, 1'b1, 1'b0, 0, 4, "p07e");
      check_idle(0, "p07e");
      send_word(0, 9'h007, 1'b1, PAR_ODD, STOP_ONE, "p07o");
      check_frame(0, 9'h007, 8, 1'b1, 1'b0, 1'b0, 0, 4, "p07o");
      check_idle(0, "p07o");
      send_word(0, 9'h000, 1'b1, PAR_ODD, STOP_ONE, "p00o");
      check_frame(0, 9'h000, 8, 1'b1, 1'b1, 1'b0, 0, 4, "p00o");
      check_idle(0, "p00o");

      // Two stop bits; STOP2 input dropped mid-frame must not shorten it
      send_word(0, 9'h0FF, 1'b0, PAR_EVEN, STOP_TWO, "s2");
      fork
         check_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 0, 4, "s2");
         begin
            repeat (12) @(negedge CLK);
            if8.STOP2 = STOP_ONE;
         end
      join
      check_idle(0, "s2");

      // Back-to-back: 0x34 queued while 0x12 is on the line
      send_word(0, 9'h012, 1'b0, PAR_EVEN, STOP_ONE, "b2b1");
      fork
         send_word(0, 9'h034, 1'b0, PAR_EVEN, STOP_ONE, "b2b2");
         begin
            check_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b0, 0, 4, "b2b_12");
            check_frame(0, 9'h034, 8, 1'b0, 1'b0, 1'b0, 1, 4, "b2b_34");
            check_idle(0, "b2b");
         end
      join

      // Data_Valid held high across three words
      fork
         hold_feed(0, 9'h03C, 9'h0C3, 9'h081);
         begin
            check_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 0, 4, "hs_3c");
            check_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1, 4, "hs_c3");
            check_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1, 4, "hs_81");
            check_idle(0, "hs");
         end
      join
      check_quiet(0, 60, "hs_no_extra_frame");

      // baud_tick held high: one clock per bit
      tick_div = 1;
      @(negedge CLK);
      send_word(0, 9'h03C, 1'b1, PAR_ODD, STOP_TWO, "fast");
      check_frame(0, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 0, 1, "fast");
      check_idle(0, "fast");
      tick_div = 4;
      @(negedge CLK);

      // WIDTH=5 and WIDTH=9 builds
      send_word(1, 9'h015, 1'b0, PAR_EVEN, STOP_ONE, "w5");
      check_frame(1, 9'h015, 5, 1'b0, 1'b0, 1'b0, 0, 4, "w5");
      check_idle(1, "w5");
      send_word(2, 9'h1A5, 1'b1, PAR_EVEN, STOP_ONE, "w9");
      check_frame(2, 9'h1A5, 9, 1'b1, 1'b1, 1'b0, 0, 4, "w9");
      check_idle(2, "w9");

      // Reset mid-DATA with a word pending
      send_word(0, 9'h0A5, 1'b0, PAR_EVEN, STOP_ONE, "rst1");
      t = 0;
      while (tx8 !== 1'b0 && t < 100) begin
         @(negedge CLK);
         t++;
      end
      chk("rst_frame_started", 32'(tx8), 0);
      repeat (8) @(negedge CLK);
      send_word(0, 9'h05A, 1'b0, PAR_EVEN, STOP_ONE, "rst2");
      chk("rst_pre_busy", 32'(busy8), 1);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_next_cycle", 32'({tx8, busy8, if8.data_ready, fd8}), 32'(4'b1010));
      @(negedge CLK);
      RST = 1'b0;
      chk("rst_held", 32'({tx8, busy8, if8.data_ready, fd8}), 32'(4'b1010));
      check_quiet(0, 120, "rst_pending_dropped");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
